// File: rtl/channel_sequencer.sv
// Channel-select front end: synchronises/debounces the DIP switches, picks a manual
// or round-robin ADC channel, updates the SPI address only on conversion boundaries.
module channel_sequencer #(
  parameter int NUM_CH          = 8,
  parameter int ADDR_W          = 3,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int DB_W            = 5,
  parameter int SCAN_DWELL      = 4,
  parameter int BLINK_W         = 22
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [NUM_CH-1:0] channel_sel,
  input  logic              scan_en,
  input  logic              conv_done,
  output logic [ADDR_W-1:0] channel_addr_to_SPI,
  output logic              addr_valid,
  output logic [NUM_CH-1:0] led,
  output logic              sel_error
);

  localparam int DWELL_W = (SCAN_DWELL > 1) ? $clog2(SCAN_DWELL) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] MANUAL = 2'd1;
  localparam logic [1:0] SCAN   = 2'd2;

  localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0]    DB_LOAD    = DB_W'(DEBOUNCE_CYCLES - 2);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DWELL - 1);

  logic [NUM_CH-1:0]  sel_meta_reg;
  logic [NUM_CH-1:0]  sel_sync_reg;
  logic               scan_meta_reg;
  logic               scan_sync_reg;
  logic [NUM_CH-1:0]  cand_reg;
  logic [DB_W-1:0]    db_cnt_reg;
  logic [NUM_CH-1:0]  sel_stable_reg;

  logic [1:0]         state_reg;
  logic [1:0]         state_next;
  logic [ADDR_W-1:0]  addr_reg;
  logic [ADDR_W-1:0]  addr_next;
  logic               valid_reg;
  logic               valid_next;
  logic [DWELL_W-1:0] dwell_reg;
  logic [DWELL_W-1:0] dwell_next;
  logic [ADDR_W-1:0]  manual_tgt_reg;
  logic [ADDR_W-1:0]  manual_tgt_next;
  logic [BLINK_W-1:0] blink_cnt_reg;
  logic               blink_reg;
  logic               blink_next;
  logic [NUM_CH-1:0]  led_reg;
  logic [NUM_CH-1:0]  led_next;
  logic               err_reg;
  logic               err_next;

  logic               onehot;
  logic               mask_zero;
  logic [ADDR_W-1:0]  manual_idx;
  logic [NUM_CH-1:0]  rot_mask;
  logic [ADDR_W-1:0]  above_off;
  logic [ADDR_W-1:0]  next_addr;
  logic [ADDR_W-1:0]  first_addr;
  logic [1:0]         mode_state;
  logic               mode_change;
  logic               apply;

  // Input synchroniser and debounce of the switch bank
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sel_meta_reg   <= '0;
      sel_sync_reg   <= '0;
      scan_meta_reg  <= 1'b0;
      scan_sync_reg  <= 1'b0;
      cand_reg       <= '0;
      db_cnt_reg     <= '0;
      sel_stable_reg <= '0;
    end else begin
      sel_meta_reg  <= channel_sel;
      sel_sync_reg  <= sel_meta_reg;
      scan_meta_reg <= scan_en;
      scan_sync_reg <= scan_meta_reg;
      if (sel_sync_reg != cand_reg) begin
        cand_reg   <= sel_sync_reg;
        db_cnt_reg <= '0;
      end else begin
        if (db_cnt_reg != DB_LAST) begin
          db_cnt_reg <= db_cnt_reg + DB_W'(1);
        end
        // Counter is about to reach DEBOUNCE_CYCLES-1: accept the candidate
        if (db_cnt_reg == DB_LOAD) begin
          sel_stable_reg <= cand_reg;
        end
      end
    end
  end

  always_comb begin
    mask_zero  = (sel_stable_reg == '0);
    onehot     = !mask_zero && ((sel_stable_reg & (sel_stable_reg - NUM_CH'(1))) == '0);
    manual_idx = '0;
    for (int j = 0; j < NUM_CH; j++) begin
      if (sel_stable_reg[j]) begin
        manual_idx = manual_idx | ADDR_W'(j);
      end
    end
    err_next        = scan_sync_reg ? mask_zero : !onehot;
    manual_tgt_next = onehot ? manual_idx : manual_tgt_reg;
  end

  // Enable mask rotated so bit 0 is the current address
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_rot
      logic [ADDR_W-1:0] rot_idx;
      assign rot_idx      = addr_reg + ADDR_W'(gi);
      assign rot_mask[gi] = sel_stable_reg[rot_idx];
    end
  endgenerate

  always_comb begin
    above_off = '0;
    for (int j = NUM_CH - 1; j >= 1; j--) begin
      if (rot_mask[j]) begin
        above_off = ADDR_W'(j);
      end
    end
    next_addr  = addr_reg + above_off;
    first_addr = rot_mask[0] ? addr_reg : next_addr;
  end

  always_comb begin
    state_next  = state_reg;
    addr_next   = addr_reg;
    valid_next  = valid_reg;
    dwell_next  = dwell_reg;
    mode_state  = scan_sync_reg ? SCAN : MANUAL;
    mode_change = 1'b0;
    apply       = 1'b0;
    case (state_reg)
      IDLE: begin
        valid_next = 1'b0;
        dwell_next = '0;
        if (!err_next) begin
          state_next = mode_state;
        end
      end
      default: begin
        state_next  = mode_state;
        mode_change = (state_reg != mode_state);
        valid_next  = 1'b1;
        // First cycle after IDLE loads without waiting for a conversion boundary
        apply       = conv_done || !valid_reg;
        if (!scan_sync_reg) begin
          dwell_next = '0;
          if (apply) begin
            addr_next = onehot ? manual_idx : manual_tgt_reg;
          end
        end else begin
          if (mode_change) begin
            dwell_next = '0;
          end
          if (!mask_zero) begin
            if (!valid_reg) begin
              addr_next = first_addr;
            end else if (conv_done) begin
              if (!rot_mask[0]) begin
                addr_next  = next_addr;
                dwell_next = '0;
              end else if (!mode_change && dwell_reg == DWELL_LAST) begin
                addr_next  = next_addr;
                dwell_next = '0;
              end else if (!mode_change) begin
                dwell_next = dwell_reg + DWELL_W'(1);
              end
            end
          end
        end
      end
    endcase
  end

  always_comb begin
    blink_next = (blink_cnt_reg == '1) ? ~blink_reg : blink_reg;
    if (!valid_next) begin
      led_next = '0;
    end else if (err_next) begin
      led_next = {NUM_CH{blink_next}};
    end else begin
      led_next = NUM_CH'(1) << addr_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg      <= IDLE;
      addr_reg       <= '0;
      valid_reg      <= 1'b0;
      dwell_reg      <= '0;
      manual_tgt_reg <= '0;
      blink_cnt_reg  <= '0;
      blink_reg      <= 1'b0;
      led_reg        <= '0;
      err_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      addr_reg       <= addr_next;
      valid_reg      <= valid_next;
      dwell_reg      <= dwell_next;
      manual_tgt_reg <= manual_tgt_next;
      blink_cnt_reg  <= blink_cnt_reg + BLINK_W'(1);
      blink_reg      <= blink_next;
      led_reg        <= led_next;
      err_reg        <= err_next;
    end
  end

  assign channel_addr_to_SPI = addr_reg;
  assign addr_valid          = valid_reg;
  assign led                 = led_reg;
  assign sel_error           = err_reg;

endmodule

// File: tb/tb_channel_sequencer.sv
// Directed bench for channel_sequencer: acquisition timing, manual/scan selection,
// debounce glitch rejection, error blink and mid-scan reset.
module tb_channel_sequencer;

  logic       clk;
  logic       resetn;
  logic [7:0] channel_sel;
  logic       scan_en;
  logic       conv_done;
  logic [2:0] channel_addr_to_SPI;
  logic       addr_valid;
  logic [7:0] led;
  logic       sel_error;

  int check_count = 0;
  int pass_count  = 0;

  channel_sequencer #(
    .NUM_CH(8), .ADDR_W(3), .DEBOUNCE_CYCLES(4), .DB_W(3), .SCAN_DWELL(2), .BLINK_W(3)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .channel_sel(channel_sel),
    .scan_en(scan_en),
    .conv_done(conv_done),
    .channel_addr_to_SPI(channel_addr_to_SPI),
    .addr_valid(addr_valid),
    .led(led),
    .sel_error(sel_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_conv();
    conv_done = 1'b1;
    tick(1);
    conv_done = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; channel_sel = 8'b00000100; scan_en = 1'b0; conv_done = 1'b0;
    tick(3);
    check_count++;
    if (addr_valid !== 1'b0 || channel_addr_to_SPI !== 3'd0)
      $display("FAIL reset_addr: valid=%b addr=%0d, required valid=0 addr=0", addr_valid, channel_addr_to_SPI);
    else pass_count++;
    check_count++;
    if (led !== 8'h00 || sel_error !== 1'b0)
      $display("FAIL reset_led: led=%b err=%b, required led=00000000 err=0", led, sel_error);
    else pass_count++;
    $display("reset: addr=%0d valid=%b led=%b err=%b", channel_addr_to_SPI, addr_valid, led, sel_error);
  endtask

  task automatic test_acquire();
    resetn = 1'b1;
    tick(7);
    check_count++;
    if (addr_valid !== 1'b0)
      $display("FAIL acquire_early: valid=%b at cycle 7, required 0", addr_valid);
    else pass_count++;
    tick(1);
    check_count++;
    if (addr_valid !== 1'b1 || channel_addr_to_SPI !== 3'd2 || led !== 8'b00000100 || sel_error !== 1'b0)
      $display("FAIL acquire_cycle8: valid=%b addr=%0d led=%b err=%b, required valid=1 addr=2 led=00000100 err=0",
               addr_valid, channel_addr_to_SPI, led, sel_error);
    else pass_count++;
    $display("acquire: cycle 8 addr=%0d valid=%b led=%b", channel_addr_to_SPI, addr_valid, led);
  endtask

  task automatic test_manual_change();
    channel_sel = 8'b00100000;
    tick(12);
    check_count++;
    if (channel_addr_to_SPI !== 3'd2 || led !== 8'b00000100)
      $display("FAIL manual_pending: addr=%0d led=%b, required addr=2 led=00000100", channel_addr_to_SPI, led);
    else pass_count++;
    pulse_conv();
    check_count++;
    if (channel_addr_to_SPI !== 3'd5 || led !== 8'b00100000 || addr_valid !== 1'b1)
      $display("FAIL manual_apply: addr=%0d led=%b valid=%b, required addr=5 led=00100000 valid=1",
               channel_addr_to_SPI, led, addr_valid);
    else pass_count++;
    $display("manual: after conv_done addr=%0d led=%b", channel_addr_to_SPI, led);
    channel_sel = 8'b00000001;
    tick(3);
    channel_sel = 8'b00100000;
    tick(12);
    pulse_conv();
    check_count++;
    if (channel_addr_to_SPI !== 3'd5 || led !== 8'b00100000 || sel_error !== 1'b0)
      $display("FAIL glitch_reject: addr=%0d led=%b err=%b, required addr=5 led=00100000 err=0",
               channel_addr_to_SPI, led, sel_error);
    else pass_count++;
    $display("glitch: after 3-cycle glitch and conv_done addr=%0d", channel_addr_to_SPI);
  endtask

  task automatic test_sel_error();
    int toggles;
    int last_toggle;
    logic prev;
    channel_sel = 8'b00000011;
    tick(10);
    check_count++;
    if (sel_error !== 1'b1 || channel_addr_to_SPI !== 3'd5 || addr_valid !== 1'b1)
      $display("FAIL multihot_error: err=%b addr=%0d valid=%b, required err=1 addr=5 valid=1",
               sel_error, channel_addr_to_SPI, addr_valid);
    else pass_count++;
    toggles = 0; last_toggle = -1; prev = led[0];
    for (int c = 0; c < 24; c++) begin
      tick(1);
      check_count++;
      if (led !== {8{led[0]}})
        $display("FAIL blink_uniform: led=%b at cycle %0d, required all bits equal", led, c);
      else pass_count++;
      if (led[0] !== prev) begin
        if (last_toggle >= 0) begin
          check_count++;
          if (c - last_toggle !== 8)
            $display("FAIL blink_period: toggle gap=%0d, required 8", c - last_toggle);
          else pass_count++;
        end
        last_toggle = c;
        toggles++;
        prev = led[0];
      end
    end
    check_count++;
    if (toggles < 2)
      $display("FAIL blink_toggles: toggles=%0d in 24 cycles, required >=2", toggles);
    else pass_count++;
    pulse_conv();
    check_count++;
    if (channel_addr_to_SPI !== 3'd5 || addr_valid !== 1'b1)
      $display("FAIL error_hold: addr=%0d valid=%b, required addr=5 valid=1", channel_addr_to_SPI, addr_valid);
    else pass_count++;
    $display("sel_error: err=%b addr=%0d toggles=%0d", sel_error, channel_addr_to_SPI, toggles);
  endtask

  task automatic test_scan();
    logic [2:0] exp_seq [6];
    exp_seq[0] = 3'd1; exp_seq[1] = 3'd4; exp_seq[2] = 3'd4;
    exp_seq[3] = 3'd7; exp_seq[4] = 3'd7; exp_seq[5] = 3'd1;
    channel_sel = 8'b00000010;
    tick(10);
    pulse_conv();
    check_count++;
    if (channel_addr_to_SPI !== 3'd1 || sel_error !== 1'b0)
      $display("FAIL scan_start: addr=%0d err=%b, required addr=1 err=0", channel_addr_to_SPI, sel_error);
    else pass_count++;
    channel_sel = 8'b10010010;
    scan_en = 1'b1;
    tick(10);
    check_count++;
    if (channel_addr_to_SPI !== 3'd1 || addr_valid !== 1'b1)
      $display("FAIL scan_mode_hold: addr=%0d valid=%b, required addr=1 valid=1", channel_addr_to_SPI, addr_valid);
    else pass_count++;
    for (int k = 0; k < 6; k++) begin
      pulse_conv();
      check_count++;
      if (channel_addr_to_SPI !== exp_seq[k] || led !== (8'b1 << exp_seq[k]))
        $display("FAIL scan_seq%0d: addr=%0d led=%b, required addr=%0d", k, channel_addr_to_SPI, led, exp_seq[k]);
      else pass_count++;
      $display("scan: conv_done %0d addr=%0d", k + 1, channel_addr_to_SPI);
    end
  endtask

  task automatic test_single_and_empty();
    channel_sel = 8'b10000000;
    tick(10);
    for (int k = 0; k < 5; k++) begin
      pulse_conv();
      check_count++;
      if (channel_addr_to_SPI !== 3'd7)
        $display("FAIL single_bit%0d: addr=%0d, required 7", k, channel_addr_to_SPI);
      else pass_count++;
    end
    $display("single: after 5 conv_done addr=%0d", channel_addr_to_SPI);
    channel_sel = 8'b00000000;
    tick(10);
    pulse_conv();
    check_count++;
    if (sel_error !== 1'b1 || channel_addr_to_SPI !== 3'd7 || addr_valid !== 1'b1)
      $display("FAIL empty_mask: err=%b addr=%0d valid=%b, required err=1 addr=7 valid=1",
               sel_error, channel_addr_to_SPI, addr_valid);
    else pass_count++;
    check_count++;
    if (led !== {8{led[0]}})
      $display("FAIL empty_blink: led=%b, required all bits equal", led);
    else pass_count++;
    $display("empty: err=%b addr=%0d", sel_error, channel_addr_to_SPI);
  endtask

  task automatic test_reset_mid_scan();
    channel_sel = 8'b10010010;
    tick(10);
    pulse_conv();
    pulse_conv();
    check_count++;
    if (channel_addr_to_SPI !== 3'd1 || sel_error !== 1'b0)
      $display("FAIL scan_wrap: addr=%0d err=%b, required addr=1 err=0", channel_addr_to_SPI, sel_error);
    else pass_count++;
    resetn = 1'b0;
    conv_done = 1'b1;
    tick(1);
    check_count++;
    if (addr_valid !== 1'b0 || channel_addr_to_SPI !== 3'd0 || led !== 8'h00 || sel_error !== 1'b0)
      $display("FAIL midreset: valid=%b addr=%0d led=%b err=%b, required all 0",
               addr_valid, channel_addr_to_SPI, led, sel_error);
    else pass_count++;
    resetn = 1'b1;
    conv_done = 1'b0;
    tick(7);
    check_count++;
    if (addr_valid !== 1'b0)
      $display("FAIL reacquire_early: valid=%b at cycle 7, required 0", addr_valid);
    else pass_count++;
    tick(1);
    check_count++;
    if (addr_valid !== 1'b1 || channel_addr_to_SPI !== 3'd1 || led !== 8'b00000010)
      $display("FAIL reacquire: valid=%b addr=%0d led=%b, required valid=1 addr=1 led=00000010",
               addr_valid, channel_addr_to_SPI, led);
    else pass_count++;
    $display("midreset: reacquired addr=%0d valid=%b", channel_addr_to_SPI, addr_valid);
  endtask

  initial begin
    resetn = 1'b0; channel_sel = 8'h00; scan_en = 1'b0; conv_done = 1'b0;
    test_reset();
    test_acquire();
    test_manual_change();
    test_sel_error();
    test_scan();
    test_single_and_empty();
    test_reset_mid_scan();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
